// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) built from log2(WIDTH) binary stages, optional flags via SHIFTER_FLAGS_EN.
// Latency LAT register stages; each register has its own valid/ready, so stalls collapse bubbles stage by stage.
// Backpressure: outReady low holds the last register; inReady falls once every register upstream is full.
module pipelined_barrel_shifter #(
    parameter int WIDTH          = 32,
    parameter int SHW            = $clog2(WIDTH),
    parameter int STAGES_PER_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    input  logic [SHW-1:0]   inAmt,
    input  logic [1:0]       inOp,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic             outZero,
    output logic             outCarry
`endif
);

    localparam int LAT = (SHW + STAGES_PER_REG - 1) / STAGES_PER_REG;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic [WIDTH-1:0] d_q   [LAT];
    logic [1:0]       op_q  [LAT];
    logic [SHW-1:0]   amt_q [LAT];
    logic [LAT-1:0]   v_q;

    // sources feeding each register and the value it would load
    logic [WIDTH-1:0] sd    [LAT];
    logic [1:0]       sop   [LAT];
    logic [SHW-1:0]   samt  [LAT];
    logic [LAT-1:0]   sv;
    logic [WIDTH-1:0] nd    [LAT];
    logic [LAT-1:0]   ld;

`ifdef SHIFTER_FLAGS_EN
    logic             c_q   [LAT];
    logic             sc    [LAT];
    logic             nc    [LAT];
    logic             z_q;
`endif

    always_comb begin
        sv[0]   = inValid;
        sd[0]   = inData;
        sop[0]  = inOp;
        samt[0] = inAmt;
`ifdef SHIFTER_FLAGS_EN
        sc[0]   = 1'b0;
`endif
        for (int i = 1; i < LAT; i++) begin
            sv[i]   = v_q[i-1];
            sd[i]   = d_q[i-1];
            sop[i]  = op_q[i-1];
            samt[i] = amt_q[i-1];
`ifdef SHIFTER_FLAGS_EN
            sc[i]   = c_q[i-1];
`endif
        end
    end

    // Register i may load unless it and every register after it are full and the output is stalled.
    always_comb begin : load_enable
        logic all_full;
        for (int i = 0; i < LAT; i++) begin
            all_full = 1'b1;
            for (int j = i; j < LAT; j++) begin
                all_full = all_full & v_q[j];
            end
            ld[i] = !all_full || outReady;
        end
    end

    assign inReady = ld[0] && !flush;

    // Stage k shifts by 2^k and belongs to register k / STAGES_PER_REG.
    always_comb begin : shift_stages
        logic [WIDTH-1:0] x;
`ifdef SHIFTER_FLAGS_EN
        logic [WIDTH-1:0] t;
        logic             c;
`endif
        for (int i = 0; i < LAT; i++) begin
            x = sd[i];
`ifdef SHIFTER_FLAGS_EN
            c = sc[i];
            t = '0;
`endif
            for (int k = 0; k < SHW; k++) begin
                if (((k / STAGES_PER_REG) == i) && samt[i][k]) begin
`ifdef SHIFTER_FLAGS_EN
                    // the bit leaving last in this stage is the carry if no later stage fires
                    if (sop[i] == OP_SLL) begin
                        t = x << ((1 << k) - 1);
                        c = t[WIDTH-1];
                    end else begin
                        t = x >> ((1 << k) - 1);
                        c = t[0];
                    end
`endif
                    case (sop[i])
                        OP_SLL:  x = x << (1 << k);
                        OP_SRL:  x = x >> (1 << k);
                        OP_SRA:  x = (x >> (1 << k)) |
                                     ({WIDTH{x[WIDTH-1]}} & ~({WIDTH{1'b1}} >> (1 << k)));
                        OP_ROR:  x = (x >> (1 << k)) | (x << (WIDTH - (1 << k)));
                        default: x = x;
                    endcase
                end
            end
            nd[i] = x;
`ifdef SHIFTER_FLAGS_EN
            nc[i] = c;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                d_q[i]   <= '0;
                op_q[i]  <= '0;
                amt_q[i] <= '0;
`ifdef SHIFTER_FLAGS_EN
                c_q[i]   <= 1'b0;
`endif
            end
`ifdef SHIFTER_FLAGS_EN
            z_q <= 1'b0;
`endif
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int i = 0; i < LAT; i++) begin
                if (ld[i]) begin
                    v_q[i] <= sv[i];
                    if (sv[i]) begin
                        d_q[i]   <= nd[i];
                        op_q[i]  <= sop[i];
                        amt_q[i] <= samt[i];
`ifdef SHIFTER_FLAGS_EN
                        c_q[i]   <= nc[i];
`endif
                    end
                end
            end
`ifdef SHIFTER_FLAGS_EN
            if (ld[LAT-1] && sv[LAT-1]) begin
                z_q <= (nd[LAT-1] == '0);
            end
`endif
        end
    end

    assign outValid = v_q[LAT-1];
    assign outData  = d_q[LAT-1];
`ifdef SHIFTER_FLAGS_EN
    assign outZero  = z_q;
    assign outCarry = c_q[LAT-1];
`endif

endmodule
